regbank_access_ctrl: RTL and testbench
======================================

Name: regbank_access_ctrl

Overview:
- Sequences and shares the 37-entry banked register file between two requesters.
- Requester A is the execute stage: single-cycle 3-read/1-write operations.
- Requester B is the block-transfer unit: LDM/STM-style multi-register lists.
- Translates logical r0-r15 into physical bank indices from the processor mode, and drives the bank's address, write and active controls.

Parameters:
- DATA_W, 32, register width.
- PADDR_W, 6, physical bank index width (entries 0-36).

Ports:
- clk1  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpsr_mode  in  5  current mode field, CPSR[4:0].
- a_valid  in  1  A requests an operation.
- a_ready  out  1  A operation accepted this cycle.
- a_raddr1, a_raddr2, a_raddr3  in  4 each  logical read registers.
- a_wr_en  in  1  A operation includes a write.
- a_waddr  in  4  logical write register.
- a_wdata  in  DATA_W  write data.
- a_rvalid  out  1  A read data valid.
- a_rdata1, a_rdata2, a_rdata3  out  DATA_W each  A read results.
- b_start  in  1  start a block transfer.
- b_ready  out  1  controller can accept b_start.
- b_list  in  16  register list, bit n selects rn.
- b_is_load  in  1  1 = load (bank writes), 0 = store (bank reads).
- b_user_bank  in  1  force user-mode mapping (^ suffix).
- b_rvalid  out  1  store data valid.
- b_rdata  out  DATA_W  store data.
- b_rreg  out  4  logical register of b_rdata.
- b_wvalid  in  1  load data offered.
- b_wready  out  1  load data consumed.
- b_wdata  in  DATA_W  load data.
- b_done  out  1  one-cycle pulse, transfer complete.
- bank_active  out  1  bank access enable.
- bank_w  out  1  bank general write.
- bank_pc_w  out  1  bank PC write.
- bank_addr1, bank_addr2, bank_addr3  out  PADDR_W each  physical indices.
- bank_write  out  DATA_W  general write data.
- bank_pc_write  out  DATA_W  PC write data.
- bank_read1, bank_read2, bank_read3  in  DATA_W each  bank read data.
- mode_err  out  1  sticky: an unrecognised mode was used.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Every output goes to 0.
  - last_grant is set to B, so A wins the first tie.
  - mode_err clears.
  - Reset mid-operation abandons the operation: no further bank writes, no b_done, a_rvalid=0.
- Mode map (combinational):
  - usr 10h and sys 1Fh: identity.
  - fiq 11h: r8-r14 map to 16-22.
  - svc 13h: r13,r14 map to 23,24.
  - abt 17h: r13,r14 map to 25,26.
  - irq 12h: r13,r14 map to 27,28.
  - und 1Bh: r13,r14 map to 29,30.
  - Any other mode: identity, and mode_err is set.
  - r15 always maps to 15.
  - The mode is sampled at accept and held for the whole operation.
  - b_user_bank=1 forces identity.
- States: IDLE, A_RD, B_XFER, B_DONE.
- IDLE:
  - a_ready=1 and b_ready=1 when the corresponding request wins.
  - A request alone is granted; B request alone is granted.
  - If a_valid and b_start are both high, the requester not in last_grant wins.
  - The loser sees ready=0 and must hold its request.
- A accept (IDLE, grant A):
  - In the same cycle: bank_active=1, bank_w=0, bank_addr1..3 = mapped a_raddr1..3.
  - Write fields are registered. Next state A_RD.
- A_RD (1 cycle):
  - a_rvalid=1, and a_rdata1..3 = bank_read1..3 registered from the accept cycle.
  - If a_wr_en and a_waddr≠15: bank_w=1, bank_addr1=mapped waddr, bank_write=wdata.
  - If a_wr_en and a_waddr=15: bank_pc_w=1, bank_pc_write=wdata.
  - Read-before-write: the same-op read returns the old value.
  - a_ready=0. Return to IDLE.
  - A-op throughput is one every 2 cycles.
- B accept:
  - Latch b_list, b_is_load, b_user_bank and mode.
  - Empty list: go to B_DONE, with no bank access.
  - Otherwise go to B_XFER.
- B_XFER, each cycle:
  - Target is the lowest set bit of the remaining list.
  - Store:
    - Drive bank_active=1, bank_addr1=mapped target, and clear the bit.
    - Next cycle: b_rvalid=1, b_rdata=bank_read1, b_rreg=target.
    - Throughput is 1 register/cycle, so b_rvalid of register n overlaps the issue of register n+1.
  - Load:
    - b_wready=1.
    - On b_wvalid, write the target (r15 uses the PC path, as in A_RD) and clear the bit.
    - Without b_wvalid, stall with the list unchanged.
  - When the list becomes empty, go to B_DONE. For stores, the last b_rvalid coincides with B_DONE.
- B_DONE: b_done=1 for one cycle, then IDLE. last_grant is updated on every grant.
- A is never granted while B is in B_XFER or B_DONE. The bank has a single owner.
- bank_active=0 and bank_w=0 whenever no access is issued.

Decomposition:
- regbank_pkg holds:
  - mode constants (MODE_USR…MODE_UND);
  - physical index bases (FIQ_BASE=16, SVC_BASE=23, ABT_BASE=25, IRQ_BASE=27, UND_BASE=29, PC_IDX=15);
  - the state enum;
  - a lowest-set-bit function.
- Sub-module regbank_mode_map: purely combinational; inputs logical register, mode and force_user; outputs physical index and bad_mode. Three instances for A reads, one for writes/B.

Test Plan:
- svc mode, A reads r13,r14,r0 -> bank_addr = 23,24,0 at accept; a_rvalid one cycle later carrying bank data.
- fiq mode, A writes r9=DEADBEEF; then usr mode, A reads r9 -> write uses index 17, read uses index 9.
- STM list 8005h in irq mode -> accesses 0, 2, 15 in successive cycles; b_rreg=0, 2, 15; b_done one cycle after the last issue.
- LDM list 0003h with b_wvalid gapped 2 cycles -> writes to 0, 1 only on wvalid; b_done follows; b_list=0 -> b_done with no bank_active.
- a_valid and b_start in the same cycle twice in a row -> first A, then B; A held off until b_done.
- Reset asserted mid-LDM -> no bank_w afterwards, outputs 0; mode 05h -> identity map, mode_err stays 1 until reset.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants, state encoding and helpers for the banked register file controller.
package regbank_pkg;

   localparam logic [4:0] MODE_USR = 5'h10;
   localparam logic [4:0] MODE_FIQ = 5'h11;
   localparam logic [4:0] MODE_IRQ = 5'h12;
   localparam logic [4:0] MODE_SVC = 5'h13;
   localparam logic [4:0] MODE_ABT = 5'h17;
   localparam logic [4:0] MODE_UND = 5'h1B;
   localparam logic [4:0] MODE_SYS = 5'h1F;

   localparam logic [5:0] FIQ_BASE = 6'd16;
   localparam logic [5:0] SVC_BASE = 6'd23;
   localparam logic [5:0] ABT_BASE = 6'd25;
   localparam logic [5:0] IRQ_BASE = 6'd27;
   localparam logic [5:0] UND_BASE = 6'd29;
   localparam logic [5:0] PC_IDX   = 6'd15;

   typedef enum logic [1:0] {IDLE, A_RD, B_XFER, B_DONE} state_t;

   typedef struct packed {
      logic       wr_en;
      logic [3:0] waddr;
   } a_wr_t;

   typedef struct packed {
      logic [15:0] list;
      logic        is_load;
      logic        user_bank;
   } b_xfer_t;

   // Index of the lowest set bit; 0 for an empty vector.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      lowest_set = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) lowest_set = 4'(i);
   endfunction

endpackage

// File: rtl/regbank_access_ctrl_if.sv
// Requester A, requester B and register bank signal bundle.
interface regbank_access_ctrl_if #(
   parameter int DATA_W  = 32,
   parameter int PADDR_W = 6
);
   logic               a_valid, a_ready;
   logic [3:0]         a_raddr1, a_raddr2, a_raddr3;
   logic               a_wr_en;
   logic [3:0]         a_waddr;
   logic [DATA_W-1:0]  a_wdata;
   logic               a_rvalid;
   logic [DATA_W-1:0]  a_rdata1, a_rdata2, a_rdata3;

   logic               b_start, b_ready;
   logic [15:0]        b_list;
   logic               b_is_load, b_user_bank;
   logic               b_rvalid;
   logic [DATA_W-1:0]  b_rdata;
   logic [3:0]         b_rreg;
   logic               b_wvalid, b_wready;
   logic [DATA_W-1:0]  b_wdata;
   logic               b_done;

   logic               bank_active, bank_w, bank_pc_w;
   logic [PADDR_W-1:0] bank_addr1, bank_addr2, bank_addr3;
   logic [DATA_W-1:0]  bank_write, bank_pc_write;
   logic [DATA_W-1:0]  bank_read1, bank_read2, bank_read3;

   modport slave (
      input  a_valid, a_raddr1, a_raddr2, a_raddr3, a_wr_en, a_waddr, a_wdata,
      output a_ready, a_rvalid, a_rdata1, a_rdata2, a_rdata3,
      input  b_start, b_list, b_is_load, b_user_bank, b_wvalid, b_wdata,
      output b_ready, b_rvalid, b_rdata, b_rreg, b_wready, b_done,
      output bank_active, bank_w, bank_pc_w, bank_addr1, bank_addr2, bank_addr3,
      output bank_write, bank_pc_write,
      input  bank_read1, bank_read2, bank_read3
   );

   modport master (
      output a_valid, a_raddr1, a_raddr2, a_raddr3, a_wr_en, a_waddr, a_wdata,
      input  a_ready, a_rvalid, a_rdata1, a_rdata2, a_rdata3,
      output b_start, b_list, b_is_load, b_user_bank, b_wvalid, b_wdata,
      input  b_ready, b_rvalid, b_rdata, b_rreg, b_wready, b_done,
      input  bank_active, bank_w, bank_pc_w, bank_addr1, bank_addr2, bank_addr3,
      input  bank_write, bank_pc_write,
      output bank_read1, bank_read2, bank_read3
   );
endinterface

// File: rtl/regbank_mode_map.sv
// Logical r0-r15 to physical bank index translation for one register port.
module regbank_mode_map
   import regbank_pkg::*;
#(
   parameter int PADDR_W = 6
) (
   input  logic [3:0]         lreg,
   input  logic [4:0]         mode,
   input  logic               force_user,
   output logic [PADDR_W-1:0] paddr,
   output logic               bad_mode
);
   logic [5:0] idx;
   logic       hi;

   always_comb begin
      idx      = {2'b00, lreg};
      bad_mode = 1'b0;
      hi       = (lreg == 4'd13) || (lreg == 4'd14);
      // r13 -> base, r14 -> base+1: lreg[1] distinguishes the pair
      if (!force_user) begin
         case (mode)
            MODE_USR, MODE_SYS: begin end
            MODE_FIQ: if (lreg >= 4'd8 && lreg <= 4'd14) idx = FIQ_BASE + {2'b00, lreg - 4'd8};
            MODE_SVC: if (hi) idx = SVC_BASE + {5'd0, lreg[1]};
            MODE_ABT: if (hi) idx = ABT_BASE + {5'd0, lreg[1]};
            MODE_IRQ: if (hi) idx = IRQ_BASE + {5'd0, lreg[1]};
            MODE_UND: if (hi) idx = UND_BASE + {5'd0, lreg[1]};
            default:  bad_mode = 1'b1;
         endcase
      end
      if (lreg == 4'd15) idx = PC_IDX;
   end

   assign paddr = PADDR_W'(idx);

endmodule

// File: rtl/regbank_access_ctrl.sv
// Arbitrates the banked register file between the execute stage (A) and the
// block-transfer unit (B), mapping logical registers through the latched mode.
module regbank_access_ctrl
   import regbank_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PADDR_W = 6
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic [4:0] cpsr_mode,
   regbank_access_ctrl_if.slave bus,
   output logic       mode_err
);
   state_t            state;
   logic              last_grant_b;
   a_wr_t             a_wr;
   logic [DATA_W-1:0] a_wdata_q;
   b_xfer_t           b_x;
   logic [4:0]        mode_q;

   logic [2:0][3:0]         rd_lreg;
   logic [2:0][PADDR_W-1:0] rd_paddr;
   logic [2:0]              rd_bad;
   logic [3:0]              tgt, w_lreg;
   logic                    w_force, w_bad;
   logic [PADDR_W-1:0]      w_paddr;
   logic [15:0]             list_nxt;
   logic                    grant_a, grant_b, a_wr_iss, b_ld_iss, b_st_iss;
   logic [DATA_W-1:0]       wr_data;

   // Read ports map through the live mode: they are only used in the accept cycle.
   assign rd_lreg = {bus.a_raddr3, bus.a_raddr2, bus.a_raddr1};
   for (genvar i = 0; i < 3; i++) begin : g_rd
      regbank_mode_map #(.PADDR_W(PADDR_W)) u_rd_map (
         .lreg(rd_lreg[i]), .mode(cpsr_mode), .force_user(1'b0),
         .paddr(rd_paddr[i]), .bad_mode(rd_bad[i])
      );
   end

   assign tgt      = lowest_set(b_x.list);
   assign list_nxt = b_x.list & ~(16'd1 << tgt);
   assign w_lreg   = (state == B_XFER) ? tgt : a_wr.waddr;
   assign w_force  = (state == B_XFER) && b_x.user_bank;

   regbank_mode_map #(.PADDR_W(PADDR_W)) u_wr_map (
      .lreg(w_lreg), .mode(mode_q), .force_user(w_force),
      .paddr(w_paddr), .bad_mode(w_bad)
   );

   assign grant_a  = !rst && (state == IDLE) && bus.a_valid && (!bus.b_start || last_grant_b);
   assign grant_b  = !rst && (state == IDLE) && bus.b_start && (!bus.a_valid || !last_grant_b);
   assign a_wr_iss = !rst && (state == A_RD) && a_wr.wr_en;
   assign b_ld_iss = !rst && (state == B_XFER) && b_x.is_load && bus.b_wvalid;
   assign b_st_iss = !rst && (state == B_XFER) && !b_x.is_load;
   assign wr_data  = (state == A_RD) ? a_wdata_q : bus.b_wdata;

   always_comb begin
      bus.a_ready       = grant_a;
      bus.b_ready       = grant_b;
      bus.b_wready      = !rst && (state == B_XFER) && b_x.is_load;
      bus.bank_active   = 1'b0;
      bus.bank_w        = 1'b0;
      bus.bank_pc_w     = 1'b0;
      bus.bank_addr1    = '0;
      bus.bank_addr2    = '0;
      bus.bank_addr3    = '0;
      bus.bank_write    = '0;
      bus.bank_pc_write = '0;
      if (grant_a) begin
         bus.bank_active = 1'b1;
         bus.bank_addr1  = rd_paddr[0];
         bus.bank_addr2  = rd_paddr[1];
         bus.bank_addr3  = rd_paddr[2];
      end else if (a_wr_iss || b_ld_iss) begin
         bus.bank_active = 1'b1;
         bus.bank_addr1  = w_paddr;
         if (w_lreg == 4'd15) begin
            bus.bank_pc_w     = 1'b1;
            bus.bank_pc_write = wr_data;
         end else begin
            bus.bank_w     = 1'b1;
            bus.bank_write = wr_data;
         end
      end else if (b_st_iss) begin
         bus.bank_active = 1'b1;
         bus.bank_addr1  = w_paddr;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state        <= IDLE;
         last_grant_b <= 1'b1;
         a_wr         <= '0;
         a_wdata_q    <= '0;
         b_x          <= '0;
         mode_q       <= '0;
         mode_err     <= 1'b0;
         bus.a_rvalid <= 1'b0;
         bus.a_rdata1 <= '0;
         bus.a_rdata2 <= '0;
         bus.a_rdata3 <= '0;
         bus.b_rvalid <= 1'b0;
         bus.b_rdata  <= '0;
         bus.b_rreg   <= '0;
         bus.b_done   <= 1'b0;
      end else begin
         bus.a_rvalid <= 1'b0;
         bus.b_rvalid <= 1'b0;
         bus.b_done   <= 1'b0;
         if ((a_wr_iss || b_ld_iss || b_st_iss) && w_bad) mode_err <= 1'b1;
         case (state)
            IDLE: begin
               if (grant_a) begin
                  last_grant_b <= 1'b0;
                  mode_q       <= cpsr_mode;
                  a_wr         <= '{wr_en: bus.a_wr_en, waddr: bus.a_waddr};
                  a_wdata_q    <= bus.a_wdata;
                  bus.a_rvalid <= 1'b1;
                  bus.a_rdata1 <= bus.bank_read1;
                  bus.a_rdata2 <= bus.bank_read2;
                  bus.a_rdata3 <= bus.bank_read3;
                  if (|rd_bad) mode_err <= 1'b1;
                  state        <= A_RD;
               end else if (grant_b) begin
                  last_grant_b <= 1'b1;
                  mode_q       <= cpsr_mode;
                  b_x          <= '{list: bus.b_list, is_load: bus.b_is_load,
                                    user_bank: bus.b_user_bank};
                  if (rd_bad[0] && !bus.b_user_bank) mode_err <= 1'b1;
                  if (bus.b_list == 16'd0) begin
                     bus.b_done <= 1'b1;
                     state      <= B_DONE;
                  end else begin
                     state <= B_XFER;
                  end
               end
            end
            A_RD: state <= IDLE;
            B_XFER: begin
               // Store read data returns a cycle after issue, overlapping the next issue.
               if (!b_x.is_load || bus.b_wvalid) begin
                  b_x.list <= list_nxt;
                  if (!b_x.is_load) begin
                     bus.b_rvalid <= 1'b1;
                     bus.b_rdata  <= bus.bank_read1;
                     bus.b_rreg   <= tgt;
                  end
                  if (list_nxt == 16'd0) begin
                     bus.b_done <= 1'b1;
                     state      <= B_DONE;
                  end
               end
            end
            B_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Randomized self-checking bench: a bank array model plus a shadow copy of the
// physical registers maintained from the mode/banking rules.
module tb_regbank_access_ctrl;
   logic       clk1 = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] cpsr_mode = 5'h10;
   logic       mode_err;
   int         n_tests = 0;
   int         n_fail = 0;

   regbank_access_ctrl_if #(.DATA_W(32), .PADDR_W(6)) bus ();
   regbank_access_ctrl #(.DATA_W(32), .PADDR_W(6)) dut (
      .clk1(clk1), .rst(rst), .cpsr_mode(cpsr_mode), .bus(bus), .mode_err(mode_err)
   );

   always #5 clk1 = ~clk1;

   logic [31:0] bank [0:63];
   logic [31:0] bank_seed;
   logic [31:0] ref_rf [0:63];
   int          wr_cnt = 0;
   logic [4:0]  vmodes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};

   assign bus.bank_read1 = bank[bus.bank_addr1];
   assign bus.bank_read2 = bank[bus.bank_addr2];
   assign bus.bank_read3 = bank[bus.bank_addr3];

   always @(posedge clk1) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) bank[i] <= bank_seed ^ (32'(i) * 32'h0101_0101);
      end else begin
         if (bus.bank_active && bus.bank_w) begin
            bank[bus.bank_addr1] <= bus.bank_write;
            wr_cnt <= wr_cnt + 1;
         end
         if (bus.bank_active && bus.bank_pc_w) begin
            bank[15] <= bus.bank_pc_write;
            wr_cnt <= wr_cnt + 1;
         end
      end
   end

   // Banking rules: which physical entry a logical register names in each mode.
   function automatic int exp_map(input int r, input logic [4:0] m, input bit u);
      if (u || r == 15) return r;
      case (m)
         5'h11: return (r >= 8 && r <= 14) ? 16 + (r - 8) : r;
         5'h13: return (r == 13 || r == 14) ? 23 + (r - 13) : r;
         5'h17: return (r == 13 || r == 14) ? 25 + (r - 13) : r;
         5'h12: return (r == 13 || r == 14) ? 27 + (r - 13) : r;
         5'h1B: return (r == 13 || r == 14) ? 29 + (r - 13) : r;
         default: return r;
      endcase
   endfunction

   task automatic ref_init();
      for (int i = 0; i < 64; i++) ref_rf[i] = bank_seed ^ (32'(i) * 32'h0101_0101);
   endtask

   task automatic idle_inputs();
      bus.a_valid = 0; bus.a_raddr1 = 0; bus.a_raddr2 = 0; bus.a_raddr3 = 0;
      bus.a_wr_en = 0; bus.a_waddr = 0; bus.a_wdata = 0;
      bus.b_start = 0; bus.b_list = 0; bus.b_is_load = 0; bus.b_user_bank = 0;
      bus.b_wvalid = 0; bus.b_wdata = 0;
   endtask

   task automatic cyc();
      @(posedge clk1); #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; cyc(); cyc(); rst = 0;
      ref_init();
   endtask

   task automatic test_reset();
      logic [9:0] ctl;
      logic [241:0] dat;
      bank_seed = $urandom;
      idle_inputs();
      rst = 1; cyc(); cyc();
      for (int ph = 0; ph < 2; ph++) begin
         #2;
         ctl = {bus.a_ready, bus.b_ready, bus.a_rvalid, bus.b_rvalid, bus.b_wready,
                bus.b_done, bus.bank_active, bus.bank_w, bus.bank_pc_w, mode_err};
         dat = {bus.bank_addr1, bus.bank_addr2, bus.bank_addr3, bus.bank_write,
                bus.bank_pc_write, bus.a_rdata1, bus.a_rdata2, bus.a_rdata3, bus.b_rdata, bus.b_rreg};
         n_tests++;
         if (ctl !== '0) begin n_fail++; $display("FAIL reset_ctl ph%0d: got %b exp 0", ph, ctl); end
         n_tests++;
         if (dat !== '0) begin n_fail++; $display("FAIL reset_data ph%0d: got %h exp 0", ph, dat); end
         if (ph == 0) begin rst = 0; cyc(); end
      end
      ref_init();
   endtask

   task automatic a_op(input logic [4:0] m, input logic [3:0] r1, r2, r3,
                       input bit wr, input logic [3:0] wa, input logic [31:0] wd);
      int p1, p2, p3, pw;
      logic [31:0] e1, e2, e3;
      p1 = exp_map(r1, m, 0); p2 = exp_map(r2, m, 0); p3 = exp_map(r3, m, 0);
      pw = exp_map(wa, m, 0);
      e1 = ref_rf[p1]; e2 = ref_rf[p2]; e3 = ref_rf[p3];
      cpsr_mode = m;
      bus.a_valid = 1; bus.a_raddr1 = r1; bus.a_raddr2 = r2; bus.a_raddr3 = r3;
      bus.a_wr_en = wr; bus.a_waddr = wa; bus.a_wdata = wd;
      #2;
      n_tests++;
      if ({bus.a_ready, bus.bank_active, bus.bank_w, bus.bank_pc_w} !== 4'b1100) begin
         n_fail++; $display("FAIL a_accept_ctl: got %b exp 1100",
                            {bus.a_ready, bus.bank_active, bus.bank_w, bus.bank_pc_w});
      end
      n_tests++;
      if ({bus.bank_addr1, bus.bank_addr2, bus.bank_addr3} !== {6'(p1), 6'(p2), 6'(p3)}) begin
         n_fail++; $display("FAIL a_read_addr mode %h: got %0d,%0d,%0d exp %0d,%0d,%0d", m,
                            bus.bank_addr1, bus.bank_addr2, bus.bank_addr3, p1, p2, p3);
      end
      cyc();
      bus.a_valid = 0; bus.a_wdata = $urandom; bus.a_waddr = 4'($urandom);
      cpsr_mode = vmodes[$urandom_range(0, 6)];
      #2;
      n_tests++;
      if ({bus.a_rvalid, bus.a_ready, bus.a_rdata1, bus.a_rdata2, bus.a_rdata3} !== {2'b10, e1, e2, e3}) begin
         n_fail++; $display("FAIL a_rdata: got v%b %h %h %h exp %h %h %h", bus.a_rvalid,
                            bus.a_rdata1, bus.a_rdata2, bus.a_rdata3, e1, e2, e3);
      end
      n_tests++;
      if (wr && wa == 4'd15) begin
         if ({bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.bank_pc_write} !== {3'b101, wd}) begin
            n_fail++; $display("FAIL a_pc_write: got %b %h exp 101 %h",
                               {bus.bank_active, bus.bank_w, bus.bank_pc_w}, bus.bank_pc_write, wd);
         end
      end else if (wr) begin
         if ({bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.bank_addr1, bus.bank_write} !== {3'b110, 6'(pw), wd}) begin
            n_fail++; $display("FAIL a_write: got %b idx %0d %h exp 110 idx %0d %h",
                               {bus.bank_active, bus.bank_w, bus.bank_pc_w}, bus.bank_addr1, bus.bank_write, pw, wd);
         end
      end else begin
         if ({bus.bank_active, bus.bank_w, bus.bank_pc_w} !== 3'b000) begin
            n_fail++; $display("FAIL a_no_write: got %b exp 000", {bus.bank_active, bus.bank_w, bus.bank_pc_w});
         end
      end
      if (wr) ref_rf[pw] = wd;
      cyc();
   endtask

   task automatic b_xfer(input logic [4:0] m, input logic [15:0] list, input bit load,
                         input bit u, input int gap);
      int tq[$];
      int n, pl;
      logic [31:0] wd;
      for (int i = 0; i < 16; i++) if (list[i]) tq.push_back(i);
      n = tq.size();
      cpsr_mode = m; bus.b_start = 1; bus.b_list = list; bus.b_is_load = load; bus.b_user_bank = u;
      #2;
      n_tests++;
      if ({bus.b_ready, bus.a_ready, bus.bank_active} !== 3'b100) begin
         n_fail++; $display("FAIL b_accept: got %b exp 100", {bus.b_ready, bus.a_ready, bus.bank_active});
      end
      cyc();
      bus.b_start = 0; bus.b_list = 16'($urandom); bus.b_is_load = ~load; bus.b_user_bank = ~u;
      cpsr_mode = vmodes[$urandom_range(0, 6)];
      for (int k = 0; k < n; k++) begin
         int p;
         p = exp_map(tq[k], m, u);
         if (load) begin
            for (int g = 0; g < gap; g++) begin
               bus.b_wvalid = 0; #2;
               n_tests++;
               if ({bus.b_wready, bus.bank_active, bus.b_done} !== 3'b100) begin
                  n_fail++; $display("FAIL b_load_stall: got %b exp 100", {bus.b_wready, bus.bank_active, bus.b_done});
               end
               cyc();
            end
            wd = $urandom; bus.b_wvalid = 1; bus.b_wdata = wd; #2;
            n_tests++;
            if (tq[k] == 15) begin
               if ({bus.b_wready, bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.bank_pc_write} !== {4'b1101, wd}) begin
                  n_fail++; $display("FAIL b_load_pc: got %b %h exp 1101 %h",
                                     {bus.b_wready, bus.bank_active, bus.bank_w, bus.bank_pc_w}, bus.bank_pc_write, wd);
               end
            end else if ({bus.b_wready, bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.bank_addr1, bus.bank_write}
                         !== {4'b1110, 6'(p), wd}) begin
               n_fail++; $display("FAIL b_load r%0d: got %b idx %0d %h exp 1110 idx %0d %h", tq[k],
                                  {bus.b_wready, bus.bank_active, bus.bank_w, bus.bank_pc_w}, bus.bank_addr1, bus.bank_write, p, wd);
            end
            ref_rf[p] = wd;
         end else begin
            #2;
            n_tests++;
            if ({bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.bank_addr1} !== {3'b100, 6'(p)}) begin
               n_fail++; $display("FAIL b_store_issue r%0d: got %b idx %0d exp 100 idx %0d", tq[k],
                                  {bus.bank_active, bus.bank_w, bus.bank_pc_w}, bus.bank_addr1, p);
            end
            if (k > 0) begin
               pl = exp_map(tq[k-1], m, u);
               n_tests++;
               if ({bus.b_rvalid, bus.b_rreg, bus.b_rdata} !== {1'b1, 4'(tq[k-1]), ref_rf[pl]}) begin
                  n_fail++; $display("FAIL b_store_data: got v%b r%0d %h exp r%0d %h",
                                     bus.b_rvalid, bus.b_rreg, bus.b_rdata, tq[k-1], ref_rf[pl]);
               end
            end
         end
         cyc();
      end
      bus.b_wvalid = 0; #2;
      n_tests++;
      if ({bus.b_done, bus.bank_active} !== 2'b10) begin
         n_fail++; $display("FAIL b_done: got %b exp 10", {bus.b_done, bus.bank_active});
      end
      n_tests++;
      if (!load && n > 0) begin
         pl = exp_map(tq[n-1], m, u);
         if ({bus.b_rvalid, bus.b_rreg, bus.b_rdata} !== {1'b1, 4'(tq[n-1]), ref_rf[pl]}) begin
            n_fail++; $display("FAIL b_store_last: got v%b r%0d %h exp r%0d %h",
                               bus.b_rvalid, bus.b_rreg, bus.b_rdata, tq[n-1], ref_rf[pl]);
         end
      end else if (bus.b_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL b_no_rvalid: got %b exp 0", bus.b_rvalid);
      end
      cyc(); #2;
      n_tests++;
      if ({bus.b_done, bus.b_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL b_done_pulse: got %b exp 00", {bus.b_done, bus.b_rvalid});
      end
      #1; // realign to posedge+1
      cyc();
   endtask

   task automatic test_svc_read();
      a_op(5'h13, 4'd13, 4'd14, 4'd0, 0, 4'd0, 32'h0);
   endtask

   task automatic test_fiq_write();
      a_op(5'h11, 4'd0, 4'd1, 4'd9, 1, 4'd9, 32'hDEADBEEF);
      a_op(5'h10, 4'd9, 4'd8, 4'd14, 0, 4'd0, 32'h0);
      a_op(5'h11, 4'd9, 4'd15, 4'd7, 1, 4'd15, 32'h0000_1234);
   endtask

   task automatic test_block();
      b_xfer(5'h12, 16'h8005, 0, 0, 0);
      b_xfer(5'h10, 16'h0003, 1, 0, 2);
      b_xfer(5'h10, 16'h0000, 0, 0, 0);
      b_xfer(5'h11, 16'h7F00, 1, 1, 1);
      for (int i = 0; i < 10; i++)
         b_xfer(vmodes[$urandom_range(0, 6)], 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
   endtask

   task automatic test_random_a();
      for (int i = 0; i < 24; i++)
         a_op(vmodes[$urandom_range(0, 6)], 4'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 4'($urandom), $urandom);
   endtask

   task automatic test_back_to_back();
      bit seen;
      do_reset();
      cpsr_mode = 5'h10;
      bus.a_valid = 1; bus.a_raddr1 = 1; bus.a_raddr2 = 2; bus.a_raddr3 = 3; bus.a_wr_en = 0;
      bus.b_start = 1; bus.b_list = 16'h0006; bus.b_is_load = 0; bus.b_user_bank = 0;
      #2; n_tests++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10) begin n_fail++; $display("FAIL tie1: got %b exp 10", {bus.a_ready, bus.b_ready}); end
      cyc(); #2; n_tests++;
      if ({bus.a_ready, bus.b_ready, bus.a_rvalid} !== 3'b001) begin
         n_fail++; $display("FAIL tie_ard: got %b exp 001", {bus.a_ready, bus.b_ready, bus.a_rvalid});
      end
      cyc(); #2; n_tests++;
      if ({bus.a_ready, bus.b_ready} !== 2'b01) begin n_fail++; $display("FAIL tie2: got %b exp 01", {bus.a_ready, bus.b_ready}); end
      cyc(); bus.b_start = 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         #2; n_tests++;
         if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL a_held cyc%0d: got %b exp 0", c, bus.a_ready); end
         if (bus.b_done === 1'b1) seen = 1;
         cyc();
      end
      n_tests++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done_timeout: got %b exp 1", seen); end
      bus.b_start = 1;
      #2; n_tests++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10) begin n_fail++; $display("FAIL tie3: got %b exp 10", {bus.a_ready, bus.b_ready}); end
      cyc(); idle_inputs(); cyc(); cyc();
   endtask

   task automatic test_reset_mid_ldm();
      int wc;
      cpsr_mode = 5'h10;
      bus.b_start = 1; bus.b_list = 16'h00F0; bus.b_is_load = 1; bus.b_user_bank = 0;
      cyc(); bus.b_start = 0;
      bus.b_wvalid = 1; bus.b_wdata = $urandom; #2;
      n_tests++;
      if ({bus.bank_w, bus.bank_addr1} !== {1'b1, 6'd4}) begin
         n_fail++; $display("FAIL ldm_first: got w%b idx %0d exp w1 idx 4", bus.bank_w, bus.bank_addr1);
      end
      cyc();
      rst = 1; #2;
      n_tests++;
      if ({bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.b_wready} !== 4'b0000) begin
         n_fail++; $display("FAIL rst_cycle: got %b exp 0000", {bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.b_wready});
      end
      cyc(); rst = 0; ref_init();
      wc = wr_cnt;
      for (int c = 0; c < 4; c++) begin
         #2; n_tests++;
         if ({bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.b_done, bus.b_wready, bus.a_rvalid, bus.b_rvalid} !== 7'b0) begin
            n_fail++; $display("FAIL post_rst cyc%0d: got %b exp 0", c,
                               {bus.bank_active, bus.bank_w, bus.bank_pc_w, bus.b_done, bus.b_wready, bus.a_rvalid, bus.b_rvalid});
         end
         cyc();
      end
      n_tests++;
      if (wr_cnt !== wc) begin n_fail++; $display("FAIL post_rst_writes: got %0d exp %0d", wr_cnt, wc); end
      bus.b_wvalid = 0;
   endtask

   task automatic test_mode_err();
      #2; n_tests++;
      if (mode_err !== 1'b0) begin n_fail++; $display("FAIL mode_err_clear: got %b exp 0", mode_err); end
      #1;
      a_op(5'h05, 4'd13, 4'd14, 4'd8, 0, 4'd0, 32'h0);
      #2; n_tests++;
      if (mode_err !== 1'b1) begin n_fail++; $display("FAIL mode_err_set: got %b exp 1", mode_err); end
      #1;
      a_op(5'h13, 4'd13, 4'd2, 4'd3, 0, 4'd0, 32'h0);
      b_xfer(5'h17, 16'h6000, 0, 0, 0);
      #2; n_tests++;
      if (mode_err !== 1'b1) begin n_fail++; $display("FAIL mode_err_sticky: got %b exp 1", mode_err); end
      #1;
      do_reset();
      #2; n_tests++;
      if (mode_err !== 1'b0) begin n_fail++; $display("FAIL mode_err_reset: got %b exp 0", mode_err); end
      #1;
   endtask

   initial begin
      test_reset();
      test_svc_read();
      test_fiq_write();
      test_block();
      test_random_a();
      test_back_to_back();
      test_reset_mid_ldm();
      test_mode_err();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
